// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler for a shared 16:1 mux: grants one requester at a time,
// holds it for up to BURST accepted transfers, then rotates priority past it.
module mux16_rr_sched #(
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        ready,
  output logic [3:0]  sel,
  output logic [15:0] grant,
  output logic        valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg;
  logic [3:0]  sel_reg;
  logic [15:0] grant_reg;
  logic        valid_reg;
  logic [3:0]  ptr_reg;
  logic [3:0]  cnt_reg;

  logic [3:0]  arb_start;
  logic [15:0] rot_req;
  logic        arb_found;
  logic [3:0]  arb_off;
  logic [3:0]  arb_idx;
  logic        last_xfer;

  // Idle searches from the stored pointer; a releasing grant searches from
  // the slot after itself, so its own index is naturally checked last.
  assign arb_start = (state_reg == IDLE) ? ptr_reg : sel_reg + 4'd1;

  // rot_req[k] is the request k positions after arb_start (mod 16).
  for (genvar gi = 0; gi < 16; gi++) begin : g_rot
    assign rot_req[gi] = req[arb_start + 4'(gi)];
  end

  always_comb begin
    arb_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (rot_req[i]) arb_off = 4'(i);
    end
  end

  assign arb_found = |rot_req;
  assign arb_idx   = arb_start + arb_off;

  // A dropped request marks the current transfer as the last of the grant.
  assign last_xfer = (cnt_reg == 4'(BURST - 1)) || !req[sel_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= 4'd0;
      grant_reg <= 16'd0;
      valid_reg <= 1'b0;
      ptr_reg   <= 4'd0;
      cnt_reg   <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_found) begin
            state_reg <= BUSY;
            sel_reg   <= arb_idx;
            grant_reg <= 16'd1 << arb_idx;
            valid_reg <= 1'b1;
            cnt_reg   <= 4'd0;
          end
        end
        BUSY: begin
          if (ready) begin
            if (last_xfer) begin
              ptr_reg <= sel_reg + 4'd1;
              if (arb_found) begin
                sel_reg   <= arb_idx;
                grant_reg <= 16'd1 << arb_idx;
                cnt_reg   <= 4'd0;
              end else begin
                state_reg <= IDLE;
                grant_reg <= 16'd0;
                valid_reg <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + 4'd1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sel   = sel_reg;
  assign grant = grant_reg;
  assign valid = valid_reg;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Bench for mux16_rr_sched: three instances (BURST 4, 1, 2) share stimulus and
// are compared every cycle against a queue-free behavioural arbiter model.
module tb_mux16_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        ready;

  logic [3:0]  sel_d   [3];
  logic [15:0] grant_d [3];
  logic        valid_d [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux16_rr_sched #(.BURST(4)) u_b4 (.clk(clk), .rst(rst), .req(req), .ready(ready),
    .sel(sel_d[0]), .grant(grant_d[0]), .valid(valid_d[0]));
  mux16_rr_sched #(.BURST(1)) u_b1 (.clk(clk), .rst(rst), .req(req), .ready(ready),
    .sel(sel_d[1]), .grant(grant_d[1]), .valid(valid_d[1]));
  mux16_rr_sched #(.BURST(2)) u_b2 (.clk(clk), .rst(rst), .req(req), .ready(ready),
    .sel(sel_d[2]), .grant(grant_d[2]), .valid(valid_d[2]));

  // Behavioural model state per instance
  bit m_busy [3];
  int m_sel  [3];
  int m_cnt  [3];
  int m_ptr  [3];
  int m_xfer [3][16];
  int d_xfer [3][16];

  function automatic int burst_of(int b);
    return (b == 0) ? 4 : (b == 1) ? 1 : 2;
  endfunction

  // First requester found walking circularly from start; -1 if none.
  function automatic int find_from(int start, logic [15:0] r);
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  initial begin
    for (int b = 0; b < 3; b++) begin
      m_busy[b] = 0; m_sel[b] = 0; m_cnt[b] = 0; m_ptr[b] = 0;
      for (int i = 0; i < 16; i++) begin
        m_xfer[b][i] = 0;
        d_xfer[b][i] = 0;
      end
    end
  end

  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      int w;
      if (!rst && valid_d[b] && ready) d_xfer[b][sel_d[b]]++;
      if (rst) begin
        m_busy[b] = 0; m_sel[b] = 0; m_cnt[b] = 0; m_ptr[b] = 0;
      end else if (!m_busy[b]) begin
        w = find_from(m_ptr[b], req);
        if (w >= 0) begin
          m_busy[b] = 1; m_sel[b] = w; m_cnt[b] = 0;
        end
      end else if (ready) begin
        m_xfer[b][m_sel[b]]++;
        if (m_cnt[b] == burst_of(b) - 1 || !req[m_sel[b]]) begin
          m_ptr[b] = (m_sel[b] + 1) % 16;
          w = find_from(m_ptr[b], req);
          if (w >= 0) begin
            m_sel[b] = w; m_cnt[b] = 0;
          end else begin
            m_busy[b] = 0;
          end
        end else begin
          m_cnt[b] = m_cnt[b] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model plus structural invariants.
  always @(negedge clk) begin
    for (int b = 0; b < 3; b++) begin
      logic [15:0] exp_grant;
      exp_grant = m_busy[b] ? (16'd1 << m_sel[b]) : 16'd0;
      chk($sformatf("model_sel[%0d]", b), 32'(sel_d[b]), 32'(m_sel[b]));
      chk($sformatf("model_grant[%0d]", b), 32'(grant_d[b]), 32'(exp_grant));
      chk($sformatf("model_valid[%0d]", b), 32'(valid_d[b]), 32'(m_busy[b]));
      chk($sformatf("inv_onehot[%0d]", b), 32'($onehot0(grant_d[b])), 32'd1);
      chk($sformatf("inv_grant_valid[%0d]", b), 32'(grant_d[b] != 16'd0), 32'(valid_d[b]));
      if (valid_d[b]) chk($sformatf("inv_grant_sel[%0d]", b), 32'(grant_d[b][sel_d[b]]), 32'd1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 16'hFFFF; ready = 1'b1;

    // T1: reset holds everything low, also for the cycle after release
    tick();
    chk("t1_grant", 32'(grant_d[0]), 32'h0);
    chk("t1_valid", 32'(valid_d[0]), 32'h0);
    tick();
    chk("t1_sel", 32'(sel_d[0]), 32'h0);
    rst = 1'b0;
    #1;
    chk("t1_after_valid", 32'(valid_d[0]), 32'h0);
    tick();
    chk("t1_first_grant", 32'(grant_d[0]), 32'h0001);

    // T2: lone requester is re-granted without a bubble
    do_reset();
    req = 16'h0020; ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t2_sel_%0d", k), 32'(sel_d[0]), 32'd5);
      chk($sformatf("t2_grant_%0d", k), 32'(grant_d[0]), 32'h0020);
      chk($sformatf("t2_valid_%0d", k), 32'(valid_d[0]), 32'd1);
    end

    // T3: fairness with BURST=1
    do_reset();
    req = 16'hFFFF; ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      chk($sformatf("t3_sel_%0d", k), 32'(sel_d[1]), 32'(k % 16));
      chk($sformatf("t3_valid_%0d", k), 32'(valid_d[1]), 32'd1);
    end

    // T4: wrap between 15 and 0
    do_reset();
    req = 16'h8001; ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t4_sel_%0d", k), 32'(sel_d[1]), (k % 2) ? 32'd15 : 32'd0);
      chk($sformatf("t4_grant_%0d", k), 32'(grant_d[1]), (k % 2) ? 32'h8000 : 32'h0001);
    end

    // T5: backpressure freezes the grant (BURST=2)
    do_reset();
    req = 16'h0008; ready = 1'b0;
    tick();
    chk("t5_sel_init", 32'(sel_d[2]), 32'd3);
    req = 16'h00F0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t5_hold_sel_%0d", k), 32'(sel_d[2]), 32'd3);
      chk($sformatf("t5_hold_grant_%0d", k), 32'(grant_d[2]), 32'h0008);
    end
    req = 16'h00F8; ready = 1'b1;
    tick();
    chk("t5_after_xfer_sel", 32'(sel_d[2]), 32'd3);
    ready = 1'b0;
    tick();
    chk("t5_stall_sel", 32'(sel_d[2]), 32'd3);
    ready = 1'b1;
    tick();
    chk("t5_burst_end_sel", 32'(sel_d[2]), 32'd4);
    chk("t5_burst_end_grant", 32'(grant_d[2]), 32'h0010);

    // T6: early release, then reset mid-burst
    do_reset();
    req = 16'h0018; ready = 1'b0;
    tick();
    chk("t6_sel_init", 32'(sel_d[0]), 32'd3);
    req = 16'h0010; ready = 1'b1;
    tick();
    chk("t6_early_sel", 32'(sel_d[0]), 32'd4);
    chk("t6_early_grant", 32'(grant_d[0]), 32'h0010);
    rst = 1'b1;
    tick();
    chk("t6_rst_grant", 32'(grant_d[0]), 32'h0);
    chk("t6_rst_valid", 32'(valid_d[0]), 32'h0);
    chk("t6_rst_sel", 32'(sel_d[0]), 32'h0);
    rst = 1'b0;

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      req   = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom & $urandom);
      ready = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; req = 16'h0; ready = 1'b0;
    tick();

    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("xfer_count[%0d][%0d]", b, i), 32'(d_xfer[b][i]), 32'(m_xfer[b][i]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
